store_buffer: RTL and testbench
===============================

Name: store_buffer

Overview:
- In-order FIFO of committed stores sitting directly upstream of the data memory write port.
- Accepts stores from the execute/commit stage and drains one per cycle into memory when memory is not busy.
- Lets loads see pending stores by address match, so load results stay consistent with program order.

Parameters:
- DATA_WIDTH, 32, width of store data.
- ADDR_WIDTH, 32, width of store/load word address.
- DEPTH, 4, number of buffered stores. Power of two, at least 2.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous reset, active-low (buffer cleared while 0).
- st_valid  input  1  store request from commit stage.
- st_addr  input  ADDR_WIDTH  store word address.
- st_data  input  DATA_WIDTH  store data.
- st_ready  output  1  buffer can accept a store this cycle.
- ld_valid  input  1  load lookup request.
- ld_addr  input  ADDR_WIDTH  load word address.
- ld_hit  output  1  youngest matching pending store found.
- ld_data  output  DATA_WIDTH  data of youngest matching store.
- ld_stall  output  1  load must retry (used only without forwarding).
- mem_busy  input  1  memory write port unavailable this cycle.
- mem_write_enable  output  1  drive memory write_enable[0].
- mem_write_addr  output  ADDR_WIDTH  drive memory write_addr[0].
- mem_write_data  output  DATA_WIDTH  drive memory write_data[0].
- count  output  $clog2(DEPTH)+1  number of occupied entries.
- empty  output  1  count==0.
- full  output  1  count==DEPTH.

Behaviour:
- State: entry array (addr, data, valid), head ptr, tail ptr, count. Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Reset (reset==0, async): head=tail=0, count=0, all valid=0. Outputs during reset: st_ready=1, empty=1, full=0, mem_write_enable=0, ld_hit=0, ld_stall=0, ld_data=0, mem_write_addr=0, mem_write_data=0.
- Enqueue:
  - st_ready = !full. Same-cycle drain does not free a slot for that cycle's enqueue.
  - On st_valid && st_ready: entry[tail] <= {st_addr, st_data, 1}; tail advances.
  - st_valid while full: store is not accepted and state is unchanged. The producer must hold the store.
- Drain (combinational handshake to memory):
  - mem_write_enable = !empty && !mem_busy.
  - mem_write_addr and mem_write_data = entry[head] whenever !empty. Both are 0 when empty.
  - On a drain cycle, at the rising edge: entry[head].valid <= 0 and head advances. Memory captures the write on the same edge.
- Count:
  - +1 on enqueue only, -1 on drain only.
  - Unchanged on simultaneous enqueue and drain (legal only when not full at cycle start).
  - Never exceeds DEPTH and never goes below 0.
- Forwarding lookup (combinational, same cycle):
  - Scan valid entries from oldest to youngest. The youngest entry with addr==ld_addr wins.
  - The entry being drained this cycle is still visible, because memory does not hold it until the next edge.
  - ld_hit=0 and ld_data=0 when ld_valid=0 or there is no match.
  - The store being enqueued in the same cycle is not visible until the next cycle.
- Ordering: drains occur strictly in enqueue order. Stores to the same address are never merged.
- Reset mid-operation: all pending stores are discarded and mem_write_enable drops immediately (asynchronously).

Optional Feature:
- STORE_BUFFER_FORWARD_EN defined:
  - ld_hit and ld_data behave as above.
  - ld_stall is tied to 0.
- Not defined:
  - ld_hit=0 and ld_data=0 always.
  - ld_stall = ld_valid && (any valid entry addr==ld_addr). The load retries until the matching entries have drained.
  - The forwarding mux is not built.

Test Plan:
- Reset, then store (addr 5, data 100) with mem_busy=0 → next cycle mem_write_enable=1, addr 5, data 100. The following cycle empty=1 and count=0.
- Hold mem_busy=1 and issue 4 stores (addr 1..4, data 10..40) → full=1, st_ready=0. A 5th st_valid is not accepted and count stays 4. Release mem_busy → drains occur in order 1,2,3,4 on 4 consecutive cycles.
- Hold mem_busy=1, store (7,11) then (7,22), load addr 7 → forward build: ld_hit=1, ld_data=22. Non-forward build: ld_stall=1. Load addr 8 → ld_hit=0, ld_stall=0.
- At count=2, enqueue and drain in the same cycle → count stays 2. Wrap test: 10 stores through DEPTH=4 with intermittent mem_busy → memory contents match program order.
- Reset pulled low with 3 pending stores and mem_busy=0 → mem_write_enable=0 immediately, count=0. After release, no stale writes appear.

Source files
------------

// File: rtl/store_buffer.sv
// In-order store buffer between commit and the data-memory write port, with load lookup.
// Define STORE_BUFFER_FORWARD_EN to build the forwarding mux; otherwise matching loads stall.
module store_buffer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    st_valid,
  input  logic [ADDR_WIDTH-1:0]   st_addr,
  input  logic [DATA_WIDTH-1:0]   st_data,
  output logic                    st_ready,
  input  logic                    ld_valid,
  input  logic [ADDR_WIDTH-1:0]   ld_addr,
  output logic                    ld_hit,
  output logic [DATA_WIDTH-1:0]   ld_data,
  output logic                    ld_stall,
  input  logic                    mem_busy,
  output logic                    mem_write_enable,
  output logic [ADDR_WIDTH-1:0]   mem_write_addr,
  output logic [DATA_WIDTH-1:0]   mem_write_data,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    empty,
  output logic                    full
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]      valid_q;
  logic [PtrW-1:0]       head_q, tail_q;
  logic [CntW-1:0]       count_q;

  logic enq, drain;

  assign empty            = (count_q == '0);
  assign full             = (count_q == CntW'(DEPTH));
  assign count            = count_q;
  // A slot freed by this cycle's drain is not offered to this cycle's store.
  assign st_ready         = !full;
  assign enq              = st_valid && !full;
  assign drain            = !empty && !mem_busy;
  assign mem_write_enable = drain;
  assign mem_write_addr   = empty ? '0 : addr_q[head_q];
  assign mem_write_data   = empty ? '0 : data_q[head_q];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (enq) begin
        addr_q[tail_q]  <= st_addr;
        data_q[tail_q]  <= st_data;
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PtrW'(1);
      end
      if (drain) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PtrW'(1);
      end
      unique case ({enq, drain})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef STORE_BUFFER_FORWARD_EN
  logic [PtrW-1:0] scan_idx;

  // Walk oldest to youngest so the last match (youngest) overrides earlier ones.
  always_comb begin
    ld_hit   = 1'b0;
    ld_data  = '0;
    scan_idx = head_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      scan_idx = head_q + PtrW'(i);
      if (ld_valid && valid_q[scan_idx] && (addr_q[scan_idx] == ld_addr)) begin
        ld_hit  = 1'b1;
        ld_data = data_q[scan_idx];
      end
    end
  end

  assign ld_stall = 1'b0;
`else
  logic [DEPTH-1:0] match;

  always_comb begin
    match = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      match[i] = valid_q[i] && (addr_q[i] == ld_addr);
    end
  end

  assign ld_stall = ld_valid && (|match);
  assign ld_hit   = 1'b0;
  assign ld_data  = '0;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: expected memory writes are queued at enqueue and
// popped by a drain monitor; scenario tasks check flags, ordering, lookup and reset.
module tb_store_buffer;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
`ifdef STORE_BUFFER_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          st_valid = 1'b0;
  logic [AW-1:0] st_addr = '0;
  logic [DW-1:0] st_data = '0;
  logic          st_ready;
  logic          ld_valid = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic          ld_hit;
  logic [DW-1:0] ld_data;
  logic          ld_stall;
  logic          mem_busy = 1'b0;
  logic          mem_write_enable;
  logic [AW-1:0] mem_write_addr;
  logic [DW-1:0] mem_write_data;
  logic [2:0]    count;
  logic          empty;
  logic          full;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           exp_q[$];
  logic [DW-1:0] mem [64];
  logic [33:0]   exp_ld;

  store_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data),
    .ld_stall(ld_stall), .mem_busy(mem_busy), .mem_write_enable(mem_write_enable),
    .mem_write_addr(mem_write_addr), .mem_write_data(mem_write_data),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Drain monitor: every memory write must be the oldest expected store.
  always @(negedge clk) begin
    wr_t e;
    if (reset === 1'b1 && mem_write_enable === 1'b1) begin
      mem[mem_write_addr[5:0]] = mem_write_data;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL drain_unexpected got addr=%0d data=%0d required no write",
                 mem_write_addr, mem_write_data);
      end else begin
        e = exp_q.pop_front();
        if ({mem_write_addr, mem_write_data} !== {e.addr, e.data}) begin
          failures++;
          $display("FAIL drain_order got addr=%0d data=%0d required addr=%0d data=%0d",
                   mem_write_addr, mem_write_data, e.addr, e.data);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    ld_valid = 1'b1;
    ld_addr  = '0;
    #10;
    checks++;
    if ({st_ready, empty, full, mem_write_enable, ld_hit, ld_stall} !== 6'b110000) begin
      failures++;
      $display("FAIL reset_flags got %b required 110000",
               {st_ready, empty, full, mem_write_enable, ld_hit, ld_stall});
    end
    checks++;
    if ({count, mem_write_addr, mem_write_data, ld_data} !== '0) begin
      failures++;
      $display("FAIL reset_values got count=%0d waddr=%0d wdata=%0d ld_data=%0d required all 0",
               count, mem_write_addr, mem_write_data, ld_data);
    end
    ld_valid = 1'b0;
    @(negedge clk) reset = 1'b1;
  endtask

  task automatic test_basic();
    step();
    st_valid = 1'b1; st_addr = 5; st_data = 100; mem_busy = 1'b0;
    exp_q.push_back('{addr: 5, data: 100});
    step();
    st_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_write_enable, mem_write_addr, mem_write_data, count} !== {1'b1, 32'd5, 32'd100, 3'd1}) begin
      failures++;
      $display("FAIL basic_drain got we=%b addr=%0d data=%0d count=%0d required 1 5 100 1",
               mem_write_enable, mem_write_addr, mem_write_data, count);
    end
    step();
    @(negedge clk);
    checks++;
    if ({empty, count, mem_write_enable} !== {1'b1, 3'd0, 1'b0}) begin
      failures++;
      $display("FAIL basic_empty got empty=%b count=%0d we=%b required 1 0 0",
               empty, count, mem_write_enable);
    end
  endtask

  task automatic test_full();
    step();
    mem_busy = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      st_valid = 1'b1; st_addr = AW'(i); st_data = DW'(10 * i);
      exp_q.push_back('{addr: AW'(i), data: DW'(10 * i)});
      step();
    end
    st_addr = 9; st_data = 99;
    @(negedge clk);
    checks++;
    if ({full, st_ready, count} !== {1'b1, 1'b0, 3'd4}) begin
      failures++;
      $display("FAIL full_flags got full=%b st_ready=%b count=%0d required 1 0 4",
               full, st_ready, count);
    end
    step();
    st_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({full, count} !== {1'b1, 3'd4}) begin
      failures++;
      $display("FAIL full_reject got full=%b count=%0d required 1 4", full, count);
    end
    step();
    mem_busy = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++;
      if ({mem_write_enable, mem_write_addr} !== {1'b1, AW'(k)}) begin
        failures++;
        $display("FAIL full_drain_seq got we=%b addr=%0d required 1 %0d",
                 mem_write_enable, mem_write_addr, k);
      end
    end
    @(negedge clk);
    checks++;
    if ({empty, mem_write_enable} !== 2'b10) begin
      failures++;
      $display("FAIL full_drained got empty=%b we=%b required 1 0", empty, mem_write_enable);
    end
  endtask

  task automatic test_forward();
    step();
    mem_busy = 1'b1;
    st_valid = 1'b1; st_addr = 7; st_data = 11;
    exp_q.push_back('{addr: 7, data: 11});
    step();
    st_data = 22;
    exp_q.push_back('{addr: 7, data: 22});
    step();
    st_valid = 1'b0;
    ld_valid = 1'b1; ld_addr = 7;
    @(negedge clk);
    exp_ld = FWD ? {1'b1, 32'd22, 1'b0} : {1'b0, 32'd0, 1'b1};
    checks++;
    if ({ld_hit, ld_data, ld_stall} !== exp_ld) begin
      failures++;
      $display("FAIL fwd_youngest got hit=%b data=%0d stall=%b required %0h",
               ld_hit, ld_data, ld_stall, exp_ld);
    end
    ld_addr = 8;
    #1;
    checks++;
    if ({ld_hit, ld_data, ld_stall} !== 34'd0) begin
      failures++;
      $display("FAIL fwd_miss got hit=%b data=%0d stall=%b required 0 0 0",
               ld_hit, ld_data, ld_stall);
    end
    ld_valid = 1'b0; ld_addr = 7;
    #1;
    checks++;
    if ({ld_hit, ld_data, ld_stall} !== 34'd0) begin
      failures++;
      $display("FAIL fwd_no_valid got hit=%b data=%0d stall=%b required 0 0 0",
               ld_hit, ld_data, ld_stall);
    end
    step();
    ld_valid = 1'b1; ld_addr = 8;
    st_valid = 1'b1; st_addr = 8; st_data = 33;
    exp_q.push_back('{addr: 8, data: 33});
    @(negedge clk);
    checks++;
    if ({ld_hit, ld_data, ld_stall} !== 34'd0) begin
      failures++;
      $display("FAIL fwd_same_cycle_enq got hit=%b data=%0d stall=%b required 0 0 0",
               ld_hit, ld_data, ld_stall);
    end
    step();
    st_valid = 1'b0;
    exp_ld = FWD ? {1'b1, 32'd33, 1'b0} : {1'b0, 32'd0, 1'b1};
    @(negedge clk);
    checks++;
    if ({ld_hit, ld_data, ld_stall} !== exp_ld) begin
      failures++;
      $display("FAIL fwd_next_cycle got hit=%b data=%0d stall=%b required %0h",
               ld_hit, ld_data, ld_stall, exp_ld);
    end
    step();
    mem_busy = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({mem_write_addr, ld_hit, ld_data, ld_stall} !== {32'd8, exp_ld}) begin
      failures++;
      $display("FAIL fwd_draining_visible got waddr=%0d hit=%b data=%0d stall=%b required 8 %0h",
               mem_write_addr, ld_hit, ld_data, ld_stall, exp_ld);
    end
    @(negedge clk);
    checks++;
    if ({empty, ld_hit, ld_data, ld_stall} !== {1'b1, 34'd0}) begin
      failures++;
      $display("FAIL fwd_after_drain got empty=%b hit=%b data=%0d stall=%b required 1 0 0 0",
               empty, ld_hit, ld_data, ld_stall);
    end
    ld_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    step();
    mem_busy = 1'b1;
    st_valid = 1'b1; st_addr = 20; st_data = 1;
    exp_q.push_back('{addr: 20, data: 1});
    step();
    st_addr = 21; st_data = 2;
    exp_q.push_back('{addr: 21, data: 2});
    step();
    mem_busy = 1'b0;
    st_addr = 22; st_data = 3;
    exp_q.push_back('{addr: 22, data: 3});
    @(negedge clk);
    checks++;
    if ({mem_write_enable, count} !== {1'b1, 3'd2}) begin
      failures++;
      $display("FAIL b2b_before got we=%b count=%0d required 1 2", mem_write_enable, count);
    end
    step();
    st_valid = 1'b0; mem_busy = 1'b1;
    @(negedge clk);
    checks++;
    if ({count, mem_write_addr} !== {3'd2, 32'd21}) begin
      failures++;
      $display("FAIL b2b_count got count=%0d head_addr=%0d required 2 21", count, mem_write_addr);
    end
    mem_busy = 1'b0;
    for (int c = 0; c < 50 && empty !== 1'b1; c++) @(negedge clk);
    checks++;
    if (empty !== 1'b1) begin
      failures++;
      $display("FAIL b2b_drain_timeout got empty=%b required 1", empty);
    end
  endtask

  task automatic test_wrap();
    int  cyc = 0;
    bit  acc;
    step();
    for (int i = 0; i < 10; i++) begin
      st_valid = 1'b1; st_addr = AW'(32 + i % 3); st_data = DW'(1000 + i);
      acc = 1'b0;
      for (int c = 0; c < 100 && !acc; c++) begin
        mem_busy = (cyc % 3 != 0);
        cyc++;
        @(negedge clk);
        if (st_ready === 1'b1) begin
          acc = 1'b1;
          exp_q.push_back('{addr: AW'(32 + i % 3), data: DW'(1000 + i)});
        end
        step();
      end
      checks++;
      if (!acc) begin
        failures++;
        $display("FAIL wrap_accept_timeout store=%0d got not accepted required accepted", i);
      end
    end
    st_valid = 1'b0; mem_busy = 1'b0;
    for (int c = 0; c < 50 && empty !== 1'b1; c++) @(negedge clk);
    checks++;
    if (empty !== 1'b1) begin
      failures++;
      $display("FAIL wrap_drain_timeout got empty=%b required 1", empty);
    end
    checks++;
    if ({mem[32], mem[33], mem[34]} !== {32'd1009, 32'd1007, 32'd1008}) begin
      failures++;
      $display("FAIL wrap_mem got %0d %0d %0d required 1009 1007 1008",
               mem[32], mem[33], mem[34]);
    end
  endtask

  task automatic test_reset_mid();
    int stale = 0;
    step();
    mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      st_valid = 1'b1; st_addr = AW'(40 + i); st_data = DW'(500 + i);
      step();
    end
    st_valid = 1'b0;
    mem_busy = 1'b0;
    #1;
    checks++;
    if ({mem_write_enable, count} !== {1'b1, 3'd3}) begin
      failures++;
      $display("FAIL rstmid_pending got we=%b count=%0d required 1 3", mem_write_enable, count);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({mem_write_enable, count, empty} !== {1'b0, 3'd0, 1'b1}) begin
      failures++;
      $display("FAIL rstmid_async got we=%b count=%0d empty=%b required 0 0 1",
               mem_write_enable, count, empty);
    end
    step();
    @(negedge clk) reset = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (mem_write_enable === 1'b1) stale++;
    end
    checks++;
    if (stale != 0) begin
      failures++;
      $display("FAIL rstmid_stale got %0d writes required 0", stale);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_forward();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover got %0d pending required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
